// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants and a
// ceiling-log2 helper used to size pointers and the occupancy counter.
package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Smallest r with 2**r >= value; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo_flex: one synchronous write port and one
// combinational read port addressed by the FIFO read pointer.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO for any DEPTH >= 2 with standard or first-word-fall-through
// reads, programmable thresholds, synchronous flush and sticky error flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int FWFT         = MODE_STD,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 2,
  localparam int CW          = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AE_C     = CW'(ALMOST_EMPTY);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] ram_data, read_reg;
  logic                  read_valid_reg;
  logic                  wr_ok, rd_ok;
  logic [CW-1:0]         next_count;

  // Non-power-of-two depths need an explicit wrap instead of bit masking.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign wr_ok = write_en && !full;
  assign rd_ok = read_en && !empty;

  always_comb begin
    next_count = count;
    if (flush)                next_count = '0;
    else if (wr_ok && !rd_ok) next_count = count + 1'b1;
    else if (rd_ok && !wr_ok) next_count = count - 1'b1;
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PW        (PW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok && !flush),
    .waddr(wr_ptr),
    .wdata(write_data),
    .raddr(rd_ptr),
    .rdata(ram_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      full           <= 1'b0;
      empty          <= 1'b1;
      almost_full    <= 1'b0;
      almost_empty   <= 1'b1;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      read_reg       <= '0;
      read_valid_reg <= 1'b0;
    end else begin
      // Flags track the post-edge count so they never lag occupancy.
      count        <= next_count;
      full         <= (next_count == DEPTH_C);
      empty        <= (next_count == '0);
      almost_full  <= (next_count >= AF_C);
      almost_empty <= (next_count <= AE_C);
      if (flush) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        overflow       <= 1'b0;
        underflow      <= 1'b0;
        read_valid_reg <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= advance(wr_ptr);
        if (rd_ok) rd_ptr <= advance(rd_ptr);
        if (write_en && full) overflow <= 1'b1;
        if (read_en && empty) underflow <= 1'b1;
        read_valid_reg <= rd_ok;
        if (rd_ok) read_reg <= ram_data;
      end
    end
  end

  assign read_data  = (FWFT == MODE_FWFT) ? ram_data : read_reg;
  assign read_valid = (FWFT == MODE_FWFT) ? !empty : read_valid_reg;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a standard-mode and an FWFT-mode sync_fifo_flex (DEPTH=6) with the same
// stimulus and compares both against a queue-based model of the FIFO.
module tb_sync_fifo_flex;

  localparam int DEPTH = 6;

  logic       clk = 1'b0;
  logic       reset, flush, write_en, read_en;
  logic [7:0] write_data;

  logic [7:0] read_data_s, read_data_f;
  logic       read_valid_s, read_valid_f;
  logic       full_s, empty_s, almost_full_s, almost_empty_s, overflow_s, underflow_s;
  logic       full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [2:0] count_s, count_f;

  int         assert_count = 0;
  int         fail_count = 0;

  logic [7:0] model_q[$];
  logic       model_ovf, model_udf, model_rv;
  logic [7:0] model_rd;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(read_data_s), .read_valid(read_valid_s), .full(full_s),
    .empty(empty_s), .almost_full(almost_full_s), .almost_empty(almost_empty_s),
    .count(count_s), .overflow(overflow_s), .underflow(underflow_s)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(read_data_f), .read_valid(read_valid_f), .full(full_f),
    .empty(empty_f), .almost_full(almost_full_f), .almost_empty(almost_empty_f),
    .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
    model_rv  = 1'b0;
    model_rd  = 8'h00;
  endtask

  task automatic checkAll();
    int n;
    n = model_q.size();
    checkOutput("count", 32'(count_s), n);
    checkOutput("full", 32'(full_s), 32'(n == DEPTH));
    checkOutput("empty", 32'(empty_s), 32'(n == 0));
    checkOutput("almost_full", 32'(almost_full_s), 32'(n >= 4));
    checkOutput("almost_empty", 32'(almost_empty_s), 32'(n <= 2));
    checkOutput("overflow", 32'(overflow_s), 32'(model_ovf));
    checkOutput("underflow", 32'(underflow_s), 32'(model_udf));
    checkOutput("std_valid", 32'(read_valid_s), 32'(model_rv));
    checkOutput("std_data", 32'(read_data_s), 32'(model_rd));
    checkOutput("fwft_count", 32'(count_f), n);
    checkOutput("fwft_flags", {28'd0, full_f, empty_f, overflow_f, underflow_f},
                {28'd0, n == DEPTH, n == 0, model_ovf, model_udf});
    checkOutput("fwft_valid", 32'(read_valid_f), 32'(n != 0));
    if (n != 0) checkOutput("fwft_data", 32'(read_data_f), 32'(model_q[0]));
  endtask

  // One clock of stimulus: inputs set at a falling edge, model stepped at the
  // rising edge, outputs compared at the following falling edge.
  task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re, input logic fl);
    bit was_full, was_empty;
    write_en = we; write_data = wd; read_en = re; flush = fl;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (fl) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
      model_rv  = 1'b0;
    end else begin
      if (we && was_full) model_ovf = 1'b1;
      if (re && was_empty) model_udf = 1'b1;
      model_rv = 1'b0;
      if (re && !was_empty) begin
        model_rd = model_q.pop_front();
        model_rv = 1'b1;
      end
      if (we && !was_full) model_q.push_back(wd);
    end
    @(negedge clk);
    checkAll();
    write_en = 1'b0; read_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; write_en = 1'b0; read_en = 1'b0; write_data = 8'h00;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    reset = 1'b0;

    // Fill with 0x11..0x66, then one refused write of 0x77.
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);

    // Drain in order, then one refused read.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read and write at full and at empty.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Single FWFT word, then its acknowledge.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush wins over a write at count 4.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);

    // Random traffic biased toward steady streaming so pointers wrap many times.
    for (int i = 0; i < 200; i++) begin
      logic we, re, fl;
      we = ($urandom_range(0, 99) < 60);
      re = ($urandom_range(0, 99) < 55);
      fl = ($urandom_range(0, 199) == 0);
      applyStimulus(we, 8'($urandom), re, fl);
    end

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h93, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
